// File: rtl/ban_reg_micro_bank.sv
// General-purpose register file: one synchronous write port, two combinational read ports.
// Optional macro BAN_REG_WRITE_BYPASS_EN forwards write data to matching read ports in the same cycle.
module ban_reg_micro_bank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*ADDR_W-1:0] Sel_reg,
  input  logic                W,
  input  logic [DATA_W-1:0]   DW,
  output logic [DATA_W-1:0]   Rx,
  output logic [DATA_W-1:0]   Ry
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [ADDR_W-1:0] x_idx;
  logic [ADDR_W-1:0] y_idx;

  assign x_idx = Sel_reg[2*ADDR_W-1:ADDR_W];
  assign y_idx = Sel_reg[ADDR_W-1:0];

  // Reset outranks a simultaneous write; the Y field doubles as write destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (W) begin
      regs[y_idx] <= DW;
    end
  end

`ifdef BAN_REG_WRITE_BYPASS_EN
  always_comb begin
    Rx = regs[x_idx];
    Ry = regs[y_idx];
    if (W && !rst) begin
      if (x_idx == y_idx) begin
        Rx = DW;
      end
      Ry = DW;
    end
  end
`else
  always_comb begin
    Rx = regs[x_idx];
    Ry = regs[y_idx];
  end
`endif

endmodule

// File: tb/tb_ban_reg_micro_bank.sv
// Scoreboard bench for ban_reg_micro_bank: directed test-plan steps followed by random traffic.
module tb_ban_reg_micro_bank;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 2 ** ADDR_W;

  logic                clk;
  logic                rst;
  logic [2*ADDR_W-1:0] sel_reg;
  logic                w;
  logic [DATA_W-1:0]   dw;
  logic [DATA_W-1:0]   rx;
  logic [DATA_W-1:0]   ry;

  typedef struct {
    string             tag;
    logic [DATA_W-1:0] rx;
    logic [DATA_W-1:0] ry;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  // Reference register contents as the specification describes them, plus whether a reset has been seen.
  logic [DATA_W-1:0] model_mem [NREGS];
  bit                model_valid = 0;

  ban_reg_micro_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .Sel_reg (sel_reg),
    .W       (w),
    .DW      (dw),
    .Rx      (rx),
    .Ry      (ry)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic checkOutput(input exp_t e);
    checks++;
    if (rx !== e.rx) begin
      errors++;
      $display("[TB] FAIL %s Rx: actual=%h required=%h", e.tag, rx, e.rx);
    end
    checks++;
    if (ry !== e.ry) begin
      errors++;
      $display("[TB] FAIL %s Ry: actual=%h required=%h", e.tag, ry, e.ry);
    end
  endtask

  // Monitor: the outputs are settled by mid-cycle, so every negedge with a pending expectation is a check.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      checkOutput(sb_q.pop_front());
    end
  end

  // Drive one cycle of inputs, record what the reads should show before the edge, then apply the edge to the model.
  task automatic applyStimulus(input string tag, input bit r, input logic [2*ADDR_W-1:0] s,
                               input bit we, input logic [DATA_W-1:0] d);
    exp_t e;
    int xi, yi;
    @(posedge clk);
    #1;
    rst = r; sel_reg = s; w = we; dw = d;
    xi = int'(s) / NREGS;
    yi = int'(s) % NREGS;
    if (model_valid) begin
      e.tag = tag;
      e.rx  = model_mem[xi];
      e.ry  = model_mem[yi];
`ifdef BAN_REG_WRITE_BYPASS_EN
      if (we && !r) begin
        if (xi == yi) e.rx = d;
        e.ry = d;
      end
`endif
      sb_q.push_back(e);
    end
    if (r) begin
      foreach (model_mem[i]) model_mem[i] = '0;
      model_valid = 1;
    end else if (we && model_valid) begin
      model_mem[yi] = d;
    end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < NREGS; i++) begin
      applyStimulus(tag, 0, 6'(i * NREGS + ((i + 1) % NREGS)), 0, 8'h00);
    end
  endtask

  initial begin
    rst = 1; sel_reg = '0; w = 0; dw = '0;

    applyStimulus("reset", 1, 6'b000000, 0, 8'h00);
    applyStimulus("reset_read0", 0, 6'b000000, 0, 8'h00);
    applyStimulus("reset_read7", 0, 6'b111111, 0, 8'h00);

    for (int i = 0; i < NREGS; i++) begin
      applyStimulus("fill", 0, 6'(i), 1, 8'(8'h0A + i));
    end

    applyStimulus("dual_read_10", 0, 6'b001000, 0, 8'h00);
    applyStimulus("dual_read_32", 0, 6'b011010, 0, 8'h00);
    applyStimulus("dual_read_54", 0, 6'b101100, 0, 8'h00);
    applyStimulus("dual_read_76", 0, 6'b111110, 0, 8'h00);

    applyStimulus("wr_dest_r0", 0, 6'b000000, 1, 8'h01);
    applyStimulus("wr_dest_r1", 0, 6'b000001, 1, 8'h03);
    applyStimulus("wr_dest_low", 0, 6'b001000, 1, 8'h04);
    applyStimulus("wr_dest_after", 0, 6'b001000, 0, 8'h00);

    applyStimulus("same_cycle_pre", 0, 6'b010010, 1, 8'h55);
    applyStimulus("same_cycle_post", 0, 6'b010010, 0, 8'h00);

    applyStimulus("reset_midop", 1, 6'b000011, 1, 8'hFF);
    read_all("after_midop_reset");

    for (int n = 0; n < 300; n++) begin
      applyStimulus("random", ($urandom_range(0, 31) == 0), 6'($urandom),
                    $urandom_range(0, 1) == 1, 8'($urandom));
    end
    read_all("final_contents");

    applyStimulus("idle", 0, 6'b000000, 0, 8'h00);
    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: pending=%0d required=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ban_reg_micro_bank.md
Name: ban_reg_micro_bank

Overview:
- Small microcontroller general-purpose register file: 2**ADDR_W registers of DATA_W bits.
- One synchronous write port and two combinational read ports (Rx, Ry).
- Both read addresses and the write address are packed into the single select bus Sel_reg.
- Sits between the instruction decoder, which drives Sel_reg and W, and the ALU, which consumes Rx/Ry and returns results on DW.

Parameters:
- DATA_W, 8, register and data-path width in bits.
- ADDR_W, 3, register index width; register count NREGS = 2**ADDR_W (8 by default).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- Sel_reg  input  2*ADDR_W (6)  packed select.
  - Sel_reg[2*ADDR_W-1:ADDR_W] = X index: Rx read address.
  - Sel_reg[ADDR_W-1:0] = Y index: Ry read address and write destination.
- W  input  1  write enable, active-high.
- DW  input  DATA_W (8)  write data.
- Rx  output  DATA_W (8)  contents of register[X index].
- Ry  output  DATA_W (8)  contents of register[Y index].

Behaviour:
- One clock (clk); reset is synchronous and active-high on rst. No asynchronous reset path.
- Storage: NREGS x DATA_W flip-flop array r0..r(NREGS-1). No hardwired-zero register; r0 is fully writable.
- Reset: on a rising clk edge with rst=1, every register is cleared to 0.
  - Reset has priority over a simultaneous write; W/DW are ignored that cycle.
  - Rx/Ry therefore read 0 from the cycle after the reset edge.
- Write: on a rising clk edge with rst=0 and W=1, register[Sel_reg[ADDR_W-1:0]] <= DW.
  - Exactly one register is written per cycle; all others hold.
  - W=0 leaves all registers unchanged regardless of Sel_reg and DW.
- Read: Rx and Ry are purely combinational from current register contents. Zero-cycle latency from a Sel_reg change.
  - Both read ports may address the same register; both then show identical data.
- Read/write same register, same cycle (without the optional feature): the read port shows the old value until the edge and the new value after it.
- Indices wrap naturally within ADDR_W bits; no out-of-range condition exists.
- No X propagation after the first reset: outputs are always defined.

Optional Feature:
- Macro: BAN_REG_WRITE_BYPASS_EN.
- Defined: write-through bypass.
  - When W=1, rst=0 and a read index equals the write index, that read port outputs DW combinationally in the same cycle.
  - Register update still happens at the edge as normal.
- Undefined: no bypass; reads always return stored contents, as specified in Behaviour.

Test Plan:
- Reset: rst=1 for 1 edge, then Sel_reg=6'b000000, W=0 -> Rx=Ry=0x00. Also read Sel_reg=6'b111111 -> Rx=Ry=0x00.
- Sequential fill: W=1 with Sel_reg=0..7 (low field = index) and DW=0x0A,0x0B,...,0x11, one per cycle -> r0..r7 = 0x0A..0x11.
- Dual read with W=0, fill data unchanged:
  - Sel_reg=6'b001000 -> Rx=0x0B, Ry=0x0A.
  - 6'b011010 -> Rx=0x0D, Ry=0x0C.
  - 6'b101100 -> Rx=0x0F, Ry=0x0E.
  - 6'b111110 -> Rx=0x11, Ry=0x10.
- Write destination is the low field:
  - Write Sel_reg=6'b000000, DW=0x01, then Sel_reg=6'b000001, DW=0x03.
  - Then Sel_reg=6'b001000, W=1, DW=0x04.
  - After the edge: r0=0x04, Rx=r1=0x03, r1 not overwritten.
- Same-cycle read of the write target: Sel_reg=6'b010010, W=1, DW=0x55, r2 previously 0x0C.
  - Without macro: Ry=Rx=0x0C before the edge, 0x55 after.
  - With BAN_REG_WRITE_BYPASS_EN: both show 0x55 before the edge.
- Reset mid-operation: rst=1 together with W=1, Sel_reg=6'b000011, DW=0xFF -> after the edge all registers=0x00, r3 not 0xFF.
